alu_sequencer: RTL and testbench

- Multi-cycle controller that issues one 16-bit R-type instruction at a time to the combinational 16-bit ALU.
- Per instruction it decodes, reads operands from the external register file, drives the ALU and holds its inputs stable, captures the results and writes them back.
- Mul/div write back twice: lower result/quotient to the op1 register, upper result/remainder to R0.
- Sits between the instruction fetch stage and the register file/ALU pair and reports per-instruction status.

---
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: issues one R-type instruction at a time to a combinational ALU,
// reading operands from and writing results back to an external register file.
module alu_sequencer #(
  parameter int DSIZE         = 32,
  parameter int FSIZE         = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INSTR_VALID,
  input  logic [15:0]        INSTR,
  output logic               INSTR_READY,
  output logic [3:0]         RF_RADDR1,
  output logic [3:0]         RF_RADDR2,
  input  logic [DSIZE/2-1:0] RF_RDATA1,
  input  logic [DSIZE/2-1:0] RF_RDATA2,
  output logic               RF_WE,
  output logic [3:0]         RF_WADDR,
  output logic [DSIZE/2-1:0] RF_WDATA,
  output logic [FSIZE-1:0]   ALU_FUNC,
  output logic [DSIZE/2-1:0] ALU_OP1,
  output logic [DSIZE/2-1:0] ALU_OP2,
  input  logic [DSIZE/2-1:0] ALU_VALUE0,
  input  logic [DSIZE/2-1:0] ALU_VALUE1,
  input  logic               ALU_OVERFLOW,
  input  logic               ALU_INVALID,
  output logic               DONE,
  output logic [2:0]         STATUS
);
  localparam int W  = DSIZE / 2;
  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [FSIZE-1:0] FUNC_IDLE = FSIZE'(4'b1101);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB_LO, S_WB_HI, S_RETIRE
  } state_t;

  state_t        state;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;
  logic [W-1:0]  val1;
  logic          ovf;
  logic          we_q;

  logic [3:0]    fn;
  logic          illegal;
  logic          is_md;
  logic [W-1:0]  op2_sel;

  // Divide-by-zero is caught in DECODE, so the ALU's invalid flag carries no extra information.
  logic unused_alu_invalid;
  assign unused_alu_invalid = ALU_INVALID;

  assign fn      = ir[3:0];
  assign illegal = (ir[15:12] != 4'd0) || (fn == 4'd0) || (fn >= 4'd3 && fn <= 4'd7);
  assign is_md   = (fn == 4'd1) || (fn == 4'd2);
  // Shift/rotate-immediate forms take the op2 field itself as the operand.
  assign op2_sel = (fn[3:2] == 2'b10) ? W'(ir[7:4]) : RF_RDATA2;

  // Reset suppresses any write the registered enable would otherwise issue this cycle.
  assign RF_WE = we_q & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      INSTR_READY <= 1'b1;
      we_q        <= 1'b0;
      DONE        <= 1'b0;
      STATUS      <= 3'b000;
      RF_RADDR1   <= 4'd0;
      RF_RADDR2   <= 4'd0;
      RF_WADDR    <= 4'd0;
      RF_WDATA    <= '0;
      ALU_FUNC    <= FUNC_IDLE;
      ALU_OP1     <= '0;
      ALU_OP2     <= '0;
      ir          <= '0;
      cnt         <= '0;
      val1        <= '0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            ir          <= INSTR;
            RF_RADDR1   <= INSTR[11:8];
            RF_RADDR2   <= INSTR[7:4];
            INSTR_READY <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            DONE   <= 1'b1;
            STATUS <= 3'b100;
            state  <= S_RETIRE;
          end else if (fn == 4'd2 && op2_sel == '0) begin
            DONE   <= 1'b1;
            STATUS <= 3'b010;
            state  <= S_RETIRE;
          end else begin
            ALU_OP1  <= RF_RDATA1;
            ALU_OP2  <= op2_sel;
            ALU_FUNC <= FSIZE'(fn);
            cnt      <= is_md ? CW'(MULDIV_CYCLES - 1) : '0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            val1     <= ALU_VALUE1;
            ovf      <= (fn == 4'd14 || fn == 4'd15) & ALU_OVERFLOW;
            ALU_FUNC <= FUNC_IDLE;
            we_q     <= 1'b1;
            RF_WADDR <= ir[11:8];
            RF_WDATA <= ALU_VALUE0;
            state    <= S_WB_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WB_LO: begin
          if (is_md) begin
            RF_WADDR <= 4'd0;
            RF_WDATA <= val1;
            state    <= S_WB_HI;
          end else begin
            we_q   <= 1'b0;
            DONE   <= 1'b1;
            STATUS <= {2'b00, ovf};
            state  <= S_RETIRE;
          end
        end
        S_WB_HI: begin
          we_q   <= 1'b0;
          DONE   <= 1'b1;
          STATUS <= {2'b00, ovf};
          state  <= S_RETIRE;
        end
        S_RETIRE: begin
          DONE        <= 1'b0;
          STATUS      <= 3'b000;
          INSTR_READY <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU around it.
module tb_alu_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INSTR_VALID = 1'b0;
  logic [15:0] INSTR = '0;
  logic        INSTR_READY;
  logic [3:0]  RF_RADDR1, RF_RADDR2, RF_WADDR;
  logic [15:0] RF_RDATA1, RF_RDATA2, RF_WDATA;
  logic        RF_WE;
  logic [3:0]  ALU_FUNC;
  logic [15:0] ALU_OP1, ALU_OP2, ALU_VALUE0, ALU_VALUE1;
  logic        ALU_OVERFLOW, ALU_INVALID;
  logic        DONE;
  logic [2:0]  STATUS;

  always #5 CLK = ~CLK;

  alu_sequencer #(.DSIZE(32), .FSIZE(4), .MULDIV_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_READY(INSTR_READY),
    .RF_RADDR1(RF_RADDR1), .RF_RADDR2(RF_RADDR2), .RF_RDATA1(RF_RDATA1), .RF_RDATA2(RF_RDATA2),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .ALU_FUNC(ALU_FUNC), .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2),
    .ALU_VALUE0(ALU_VALUE0), .ALU_VALUE1(ALU_VALUE1),
    .ALU_OVERFLOW(ALU_OVERFLOW), .ALU_INVALID(ALU_INVALID),
    .DONE(DONE), .STATUS(STATUS)
  );

  // ALU stand-in: 0001 mul, 0010 div, 1000 srl, 1010 sll, 1100 and, 1101 or, 1111 signed add.
  logic [31:0] prod;
  logic [15:0] sum;
  always_comb begin
    prod         = 32'(ALU_OP1) * 32'(ALU_OP2);
    sum          = ALU_OP1 + ALU_OP2;
    ALU_VALUE0   = '0;
    ALU_VALUE1   = '0;
    ALU_OVERFLOW = 1'b0;
    ALU_INVALID  = 1'b0;
    case (ALU_FUNC)
      4'b0001: begin ALU_VALUE0 = prod[15:0]; ALU_VALUE1 = prod[31:16]; end
      4'b0010: begin
        if (ALU_OP2 == '0) ALU_INVALID = (ALU_OP1 == '0);
        else begin ALU_VALUE0 = ALU_OP1 / ALU_OP2; ALU_VALUE1 = ALU_OP1 % ALU_OP2; end
      end
      4'b1000: ALU_VALUE0 = ALU_OP1 >> ALU_OP2[3:0];
      4'b1010: ALU_VALUE0 = ALU_OP1 << ALU_OP2[3:0];
      4'b1100: ALU_VALUE0 = ALU_OP1 & ALU_OP2;
      4'b1101: ALU_VALUE0 = ALU_OP1 | ALU_OP2;
      4'b1111: begin
        ALU_VALUE0   = sum;
        ALU_OVERFLOW = (ALU_OP1[15] == ALU_OP2[15]) && (sum[15] != ALU_OP1[15]);
      end
      default: ALU_VALUE0 = '0;
    endcase
  end

  // Register file, preload port and event monitor.
  logic [15:0] rf [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_a = '0;
  logic [15:0] pl_d = '0;
  assign RF_RDATA1 = rf[RF_RADDR1];
  assign RF_RDATA2 = rf[RF_RADDR2];

  int cyc = 0, hs_cyc = 0, done_cyc = 0, n_hs = 0, n_done = 0, n_wr = 0;
  int busy_viol = 0, mul_exec = 0;
  logic       busy = 1'b0;
  logic [2:0] done_stat = '0;
  logic [3:0]  wl_a [64];
  logic [15:0] wl_d [64];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (INSTR_VALID && INSTR_READY && !RST) begin hs_cyc <= cyc; n_hs <= n_hs + 1; end
    if (RST) busy <= 1'b0;
    else if (INSTR_VALID && INSTR_READY) busy <= 1'b1;
    else if (DONE) busy <= 1'b0;
    if (busy && INSTR_READY) busy_viol <= busy_viol + 1;
    if (DONE) begin done_cyc <= cyc; done_stat <= STATUS; n_done <= n_done + 1; end
    if (ALU_FUNC == 4'b0001 && ALU_OP1 == 16'h1234 && ALU_OP2 == 16'h0100) mul_exec <= mul_exec + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (pl_we) rf[pl_a] <= pl_d;
    else if (RF_WE) begin
      rf[RF_WADDR]   <= RF_WDATA;
      wl_a[n_wr % 64] <= RF_WADDR;
      wl_d[n_wr % 64] <= RF_WDATA;
      n_wr <= n_wr + 1;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge CLK); pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge CLK); pl_we = 1'b0;
  endtask

  task automatic start(input logic [15:0] ins, input bit hold);
    int h0;
    h0 = n_hs;
    @(negedge CLK); INSTR = ins; INSTR_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (n_hs != h0) break;
    end
    if (!hold) INSTR_VALID = 1'b0;
    chk("handshake", n_hs - h0, 1);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < 40 && n_done == d0; i++) @(negedge CLK);
    chk(tag, n_done - d0, 1);
  endtask

  int w0, m0, d0, d1, h0;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ready", INSTR_READY, 1);
    chk("rst_we", RF_WE, 0);
    chk("rst_done", DONE, 0);
    chk("rst_status", STATUS, 0);
    chk("rst_func", ALU_FUNC, 4'b1101);
    chk("rst_op1", ALU_OP1, 0);
    chk("rst_wdata", RF_WDATA, 0);
    chk("rst_raddr1", RF_RADDR1, 0);
    RST = 1'b0;

    // Signed add with overflow: result still written, OVF reported.
    poke(1, 16'h7FFF); poke(2, 16'h0001);
    w0 = n_wr;
    start(16'h012F, 0); wait_done("add_done");
    chk("add_lat", done_cyc - hs_cyc, 4);
    chk("add_status", done_stat, 3'b001);
    chk("add_nwr", n_wr - w0, 1);
    chk("add_waddr", wl_a[w0 % 64], 1);
    chk("add_wdata", wl_d[w0 % 64], 16'h8000);

    // Multiply: two writebacks, operands held for all EXEC cycles.
    poke(3, 16'h1234); poke(4, 16'h0100);
    w0 = n_wr; m0 = mul_exec;
    start(16'h0341, 0); wait_done("mul_done");
    chk("mul_lat", done_cyc - hs_cyc, 8);
    chk("mul_status", done_stat, 0);
    chk("mul_exec", mul_exec - m0, 4);
    chk("mul_nwr", n_wr - w0, 2);
    chk("mul_lo_a", wl_a[w0 % 64], 3);
    chk("mul_lo_d", wl_d[w0 % 64], 16'h3400);
    chk("mul_hi_a", wl_a[(w0 + 1) % 64], 0);
    chk("mul_hi_d", wl_d[(w0 + 1) % 64], 16'h0012);

    // Divide by zero, then a real divide.
    poke(5, 16'd7); poke(6, 16'd0);
    w0 = n_wr;
    start(16'h0562, 0); wait_done("divz_done");
    chk("divz_lat", done_cyc - hs_cyc, 2);
    chk("divz_status", done_stat, 3'b010);
    chk("divz_nwr", n_wr - w0, 0);
    poke(6, 16'd2);
    w0 = n_wr;
    start(16'h0562, 0); wait_done("div_done");
    chk("div_lat", done_cyc - hs_cyc, 8);
    chk("div_nwr", n_wr - w0, 2);
    chk("div_q", wl_d[w0 % 64], 16'd3);
    chk("div_r_a", wl_a[(w0 + 1) % 64], 0);
    chk("div_r", wl_d[(w0 + 1) % 64], 16'd1);

    // Shift-left immediate.
    poke(7, 16'h0003);
    w0 = n_wr;
    start(16'h074A, 0); wait_done("shl_done");
    chk("shl_lat", done_cyc - hs_cyc, 4);
    chk("shl_status", done_stat, 0);
    chk("shl_nwr", n_wr - w0, 1);
    chk("shl_wdata", wl_d[w0 % 64], 16'h0030);

    // Illegal opcode and illegal func.
    w0 = n_wr;
    start(16'h1000, 0); wait_done("ill_op_done");
    chk("ill_op_lat", done_cyc - hs_cyc, 2);
    chk("ill_op_status", done_stat, 3'b100);
    start(16'h0005, 0); wait_done("ill_fn_done");
    chk("ill_fn_status", done_stat, 3'b100);
    chk("ill_nwr", n_wr - w0, 0);

    // Reset asserted during WB_LO of a multiply.
    poke(3, 16'h1234);
    w0 = n_wr; d0 = n_done;
    start(16'h0341, 0);
    repeat (5) @(negedge CLK);
    chk("rstmid_in_wblo", RF_WE, 1);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("rstmid_ready", INSTR_READY, 1);
    chk("rstmid_we", RF_WE, 0);
    repeat (12) @(negedge CLK);
    chk("rstmid_nodone", n_done - d0, 0);
    chk("rstmid_nwr", n_wr - w0, 0);
    chk("rstmid_func", ALU_FUNC, 4'b1101);

    // Back-to-back adds with INSTR_VALID held high.
    poke(1, 16'h0001); poke(2, 16'h0002); poke(3, 16'h0010); poke(4, 16'h0020);
    w0 = n_wr;
    start(16'h012F, 1);
    INSTR = 16'h034F;
    wait_done("b2b_first");
    d1 = done_cyc; h0 = n_hs;
    for (int i = 0; i < 20 && n_hs == h0; i++) @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("b2b_gap", hs_cyc - d1, 1);
    wait_done("b2b_second");
    chk("b2b_nwr", n_wr - w0, 2);
    chk("b2b_w1", {wl_a[w0 % 64], wl_d[w0 % 64]}, {4'd1, 16'h0003});
    chk("b2b_w2", {wl_a[(w0 + 1) % 64], wl_d[(w0 + 1) % 64]}, {4'd3, 16'h0030});
    chk("busy_ready", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
